// File: rtl/dma_transfer_sequencer.sv
// Four-channel DMA transfer sequencer: arbitration, S0-S4 bus cycle sequencing, terminal count tracking.
// Rotating priority is available when DMA_SEQ_ROTATING_PRIORITY_EN is defined; otherwise priority is fixed 0>1>2>3.
module dma_transfer_sequencer #(
   parameter int WC_WIDTH = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [3:0]          DREQ,
   input  logic                HLDA,
   input  logic [3:0]          maskReg,
   input  logic                priorityType,
   input  logic                singleMode,
   input  logic [1:0]          transferType,
   input  logic [WC_WIDTH-1:0] wordCountIn,
   input  logic                EOP_IN_N,
   input  logic                tcClear,
   output logic                HRQ,
   output logic [3:0]          DACK,
   output logic [1:0]          activeChannel,
   output logic                addrStrobe,
   output logic                decrWordCount,
   output logic                incrAddress,
   output logic [3:0]          tcStatus,
   output logic                MEMR_N,
   output logic                MEMW_N,
   output logic                IOR_N,
   output logic                IOW_N,
   output logic                EOP_N
);

   localparam logic [2:0] SI = 3'd0;
   localparam logic [2:0] S0 = 3'd1;
   localparam logic [2:0] S1 = 3'd2;
   localparam logic [2:0] S2 = 3'd3;
   localparam logic [2:0] S3 = 3'd4;
   localparam logic [2:0] S4 = 3'd5;

   logic [2:0]          state;
   logic [2:0]          nxt;
   logic [WC_WIDTH-1:0] cnt;
   logic [1:0]          xtype;
   logic                eop_seen;
   logic [3:0]          req;
   logic [1:0]          base;
   logic                grant_vld;
   logic [1:0]          grant_ch;
   logic                in_xfer;
   logic                strobe_phase;
   logic                chan_req;
   logic                term;
   logic                s4_done;
   logic [3:0]          tc_set;

   assign req          = DREQ & ~maskReg;
   assign chan_req     = DREQ[activeChannel];
   assign in_xfer      = (state == S1) || (state == S2) || (state == S3) || (state == S4);
   assign strobe_phase = (state == S2) || (state == S3);
   // A late EOP_IN_N sampled at the end of S4 still terminates, though EOP_N could not show it.
   assign term         = (cnt == '0) || eop_seen || !EOP_IN_N;
   assign s4_done      = (state == S4) && HLDA;
   assign tc_set       = (s4_done && term) ? (4'b0001 << activeChannel) : '0;

`ifdef DMA_SEQ_ROTATING_PRIORITY_EN
   logic [1:0] prio_base;

   assign base = priorityType ? prio_base : 2'd0;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         prio_base <= 2'd0;
      end else if (s4_done && priorityType) begin
         prio_base <= activeChannel + 2'd1;
      end
   end
`else
   logic unused_prio;

   assign unused_prio = priorityType;
   assign base        = 2'd0;
`endif

   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!grant_vld && req[2'(base + i)]) begin
            grant_vld = 1'b1;
            grant_ch  = 2'(base + i);
         end
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         SI: if (grant_vld) nxt = S0;
         S0: begin
            if (HLDA)           nxt = S1;
            else if (!chan_req) nxt = SI;
         end
         S1: nxt = HLDA ? S2 : SI;
         S2: nxt = HLDA ? S3 : SI;
         S3: nxt = HLDA ? S4 : SI;
         S4: nxt = (!HLDA || term || singleMode || !chan_req) ? SI : S1;
         default: nxt = SI;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= SI;
         activeChannel <= '0;
         cnt           <= '0;
         xtype         <= '0;
         eop_seen      <= 1'b0;
         tcStatus      <= '0;
      end else begin
         state <= nxt;
         if ((state == SI) && grant_vld) begin
            activeChannel <= grant_ch;
            cnt           <= wordCountIn;
         end
         if (nxt == S1) xtype <= transferType;
         if (s4_done) cnt <= cnt - 1'b1;
         if ((state == S1) || (state == S2) || (state == S3)) begin
            if (!EOP_IN_N) eop_seen <= 1'b1;
         end else begin
            eop_seen <= 1'b0;
         end
         tcStatus <= (tcClear ? '0 : tcStatus) | tc_set;
      end
   end

   assign HRQ           = (state != SI);
   assign DACK          = in_xfer ? (4'b0001 << activeChannel) : '0;
   assign addrStrobe    = (state == S1);
   assign decrWordCount = (state == S4);
   assign incrAddress   = (state == S4);
   assign IOR_N         = !(strobe_phase && (xtype == 2'b01));
   assign MEMW_N        = !(strobe_phase && (xtype == 2'b01));
   assign MEMR_N        = !(strobe_phase && (xtype == 2'b10));
   assign IOW_N         = !(strobe_phase && (xtype == 2'b10));
   assign EOP_N         = !((state == S4) && ((cnt == '0) || eop_seen));

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Directed self-checking bench for dma_transfer_sequencer; expected values are hand-derived per scenario.
module tb_dma_transfer_sequencer;

   localparam int WCW = 16;

   logic           CLK = 1'b0;
   logic           RESET;
   logic [3:0]     DREQ;
   logic           HLDA;
   logic [3:0]     maskReg;
   logic           priorityType;
   logic           singleMode;
   logic [1:0]     transferType;
   logic [WCW-1:0] wordCountIn;
   logic           EOP_IN_N;
   logic           tcClear;
   logic           HRQ;
   logic [3:0]     DACK;
   logic [1:0]     activeChannel;
   logic           addrStrobe;
   logic           decrWordCount;
   logic           incrAddress;
   logic [3:0]     tcStatus;
   logic           MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N;
   logic [3:0]     strb;

   dma_transfer_sequencer #(.WC_WIDTH(WCW)) dut (
      .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .maskReg(maskReg),
      .priorityType(priorityType), .singleMode(singleMode), .transferType(transferType),
      .wordCountIn(wordCountIn), .EOP_IN_N(EOP_IN_N), .tcClear(tcClear),
      .HRQ(HRQ), .DACK(DACK), .activeChannel(activeChannel), .addrStrobe(addrStrobe),
      .decrWordCount(decrWordCount), .incrAddress(incrAddress), .tcStatus(tcStatus),
      .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N)
   );

   // {MEMR_N, MEMW_N, IOR_N, IOW_N}: write = 1001, read = 0110, idle = 1111
   assign strb = {MEMR_N, MEMW_N, IOR_N, IOW_N};

   always #5 CLK = ~CLK;

   int   checks = 0;
   int   errors = 0;
   int   decr_total = 0;
   logic hlda_en = 1'b1;
   int   cyc, n_as, n_memw, n_ior, n_memr, n_decr, n_eop, eop_at, d0;
   logic [1:0] exp_order [5];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one cycle, sample #1 after the edge; the CPU grants hold in response to HRQ.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (decrWordCount) decr_total++;
      HLDA = hlda_en & HRQ;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef DMA_SEQ_ROTATING_PRIORITY_EN
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      exp_order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      RESET = 1'b1; DREQ = '0; HLDA = 1'b0; maskReg = '0; priorityType = 1'b0;
      singleMode = 1'b1; transferType = 2'b00; wordCountIn = '0; EOP_IN_N = 1'b1; tcClear = 1'b0;
      tick(); tick();
      check_eq("rst_hrq",   HRQ, 0);
      check_eq("rst_dack",  DACK, 0);
      check_eq("rst_ch",    activeChannel, 0);
      check_eq("rst_strb",  strb, 4'hF);
      check_eq("rst_pulse", {addrStrobe, decrWordCount, incrAddress}, 0);
      check_eq("rst_eop",   EOP_N, 1);
      check_eq("rst_tc",    tcStatus, 0);
      RESET = 1'b0;

      // Fixed priority, DREQ=0110: channel 1 first, single write with wordCountIn=0 (one transfer, TC)
      DREQ = 4'b0110; transferType = 2'b01; singleMode = 1'b1; wordCountIn = 0;
      tick();
      check_eq("t1_s0_hrq",  HRQ, 1);
      check_eq("t1_ch",      activeChannel, 1);
      check_eq("t1_s0_dack", DACK, 0);
      tick();
      check_eq("t1_s1_dack", DACK, 4'b0010);
      check_eq("t1_s1_as",   addrStrobe, 1);
      tick();
      check_eq("t1_s2_strb", strb, 4'b1001);
      check_eq("t1_s2_as",   addrStrobe, 0);
      tick();
      check_eq("t1_s3_strb", strb, 4'b1001);
      tcClear = 1'b1;
      tick();
      check_eq("t1_s4_strb",  strb, 4'hF);
      check_eq("t1_s4_pulse", {decrWordCount, incrAddress}, 2'b11);
      check_eq("t1_s4_eop",   EOP_N, 0);
      check_eq("t1_s4_dack",  DACK, 4'b0010);
      tick();
      check_eq("t1_tc_setwins", tcStatus, 4'b0010);
      check_eq("t1_end_hrq",    HRQ, 0);
      check_eq("t1_end_dack",   DACK, 0);
      DREQ = 4'b0000;
      tick();
      check_eq("t1_tc_clr", tcStatus, 0);
      tcClear = 1'b0;

      // Demand write on channel 0, wordCountIn=2: three transfers, EOP on the third S4
      DREQ = 4'b0001; singleMode = 1'b0; transferType = 2'b01; wordCountIn = 2;
      cyc = 0; n_as = 0; n_memw = 0; n_ior = 0; n_memr = 0; n_decr = 0; n_eop = 0; eop_at = 0;
      do begin
         tick();
         cyc++;
         if (addrStrobe)    n_as++;
         if (!MEMW_N)       n_memw++;
         if (!IOR_N)        n_ior++;
         if (!MEMR_N)       n_memr++;
         if (decrWordCount) n_decr++;
         if (!EOP_N) begin
            n_eop++;
            eop_at = n_decr;
         end
      end while (HRQ && cyc < 40);
      DREQ = 4'b0000;
      check_eq("t2_done",   HRQ, 0);
      check_eq("t2_cycles", cyc, 14);
      check_eq("t2_as",     n_as, 3);
      check_eq("t2_memw",   n_memw, 6);
      check_eq("t2_ior",    n_ior, 6);
      check_eq("t2_memr",   n_memr, 0);
      check_eq("t2_decr",   n_decr, 3);
      check_eq("t2_eop",    n_eop, 1);
      check_eq("t2_eop_at", eop_at, 3);
      check_eq("t2_tc",     tcStatus, 4'b0001);
      tcClear = 1'b1;
      tick();
      tcClear = 1'b0;

      // All channels requesting, single mode, priorityType=1
      DREQ = 4'hF; singleMode = 1'b1; priorityType = 1'b1; wordCountIn = 1;
      for (int g = 0; g < 5; g++) begin
         tick();
         check_eq($sformatf("prio_g%0d", g), activeChannel, exp_order[g]);
         cyc = 0;
         do begin
            tick();
            cyc++;
         end while (HRQ && cyc < 10);
         check_eq($sformatf("prio_rel%0d", g), HRQ, 0);
      end
      DREQ = 4'b0000; priorityType = 1'b0;
      tick();

      // HLDA dropped during S2 of a read: abort, no count pulse, no status
      DREQ = 4'b0100; transferType = 2'b10; wordCountIn = 3; singleMode = 1'b1;
      d0 = decr_total;
      tick();
      check_eq("t4_ch", activeChannel, 2);
      tick();
      tick();
      check_eq("t4_s2_strb", strb, 4'b0110);
      hlda_en = 1'b0; HLDA = 1'b0;
      tick();
      check_eq("t4_hrq",  HRQ, 0);
      check_eq("t4_dack", DACK, 0);
      check_eq("t4_strb", strb, 4'hF);
      check_eq("t4_tc",   tcStatus, 0);
      DREQ = 4'b0000;
      tick();
      check_eq("t4_nodecr", decr_total, d0);
      hlda_en = 1'b1;

      // EOP_IN_N low in S2 of a verify, wordCountIn=5, demand mode
      DREQ = 4'b1000; transferType = 2'b00; wordCountIn = 5; singleMode = 1'b0;
      tick();
      check_eq("t5_ch", activeChannel, 3);
      tick();
      tick();
      check_eq("t5_s2_strb", strb, 4'hF);
      EOP_IN_N = 1'b0;
      tick();
      EOP_IN_N = 1'b1;
      check_eq("t5_s3_eop", EOP_N, 1);
      tick();
      check_eq("t5_s4_eop",  EOP_N, 0);
      check_eq("t5_s4_decr", decrWordCount, 1);
      tick();
      check_eq("t5_hrq", HRQ, 0);
      check_eq("t5_tc",  tcStatus, 4'b1000);
      DREQ = 4'b0000; tcClear = 1'b1;
      tick();
      tcClear = 1'b0;

      // Mask mid-transfer does not abort; RESET in S3; re-arbitration honours the new mask
      DREQ = 4'b1010; transferType = 2'b01; wordCountIn = 4; singleMode = 1'b1; maskReg = 4'b0000;
      tick();
      check_eq("t6_ch", activeChannel, 1);
      tick();
      tick();
      maskReg = 4'b0010;
      tick();
      check_eq("t6_s3_dack", DACK, 4'b0010);
      check_eq("t6_s3_strb", strb, 4'b1001);
      RESET = 1'b1;
      tick();
      check_eq("t6_rst_hrq",   HRQ, 0);
      check_eq("t6_rst_dack",  DACK, 0);
      check_eq("t6_rst_ch",    activeChannel, 0);
      check_eq("t6_rst_strb",  strb, 4'hF);
      check_eq("t6_rst_pulse", {addrStrobe, decrWordCount, incrAddress}, 0);
      check_eq("t6_rst_eop",   EOP_N, 1);
      check_eq("t6_rst_tc",    tcStatus, 0);
      RESET = 1'b0;
      tick();
      check_eq("t6_rearb_ch",  activeChannel, 3);
      check_eq("t6_rearb_hrq", HRQ, 1);
      hlda_en = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
      tick();
      check_eq("t6_s0_drop_hrq",  HRQ, 0);
      check_eq("t6_s0_drop_dack", DACK, 0);
      hlda_en = 1'b1; maskReg = 4'b0000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
